cpu_control_unit: RTL and testbench

Multi-cycle fetch/decode/execute/writeback controller for the 16-bit, 4-register CPU core. It sits directly upstream of the register file. It fetches instructions from instruction memory over a req/valid handshake, drives the register file read addresses, and consumes the read data. It computes results through an ALU and drives the register file write port.

---
 rtl/cpu_pkg.sv | 52 +++++
 rtl/cpu_control_unit_alu.sv | 29 ++
 rtl/cpu_control_unit.sv | 115 +++++++++++
 tb/tb_cpu_control_unit.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit, 4-register CPU core:
// opcodes, controller states, instruction field positions and widths.
package cpu_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned REG_AW = 2;

    // Instruction field bit positions
    localparam int unsigned OP_HI  = 15;
    localparam int unsigned OP_LO  = 12;
    localparam int unsigned RD_HI  = 11;
    localparam int unsigned RD_LO  = 10;
    localparam int unsigned RS1_HI = 9;
    localparam int unsigned RS1_LO = 8;
    localparam int unsigned RS2_HI = 7;
    localparam int unsigned RS2_LO = 6;
    localparam int unsigned IMM_HI = 7;
    localparam int unsigned IMM_LO = 0;

    // Opcodes (12-14 are reserved and behave as NOP)
    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_OR   = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_MOV  = 4'd6;
    localparam logic [3:0] OP_LDI  = 4'd7;
    localparam logic [3:0] OP_JMP  = 4'd8;
    localparam logic [3:0] OP_BEQZ = 4'd9;
    localparam logic [3:0] OP_SHL  = 4'd10;
    localparam logic [3:0] OP_SHR  = 4'd11;
    localparam logic [3:0] OP_HALT = 4'd15;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_WB,
        ST_HALT
    } state_t;

    // True for opcodes that produce a register file write
    function automatic logic is_write_op(input logic [3:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
            OP_MOV, OP_LDI, OP_SHL, OP_SHR: is_write_op = 1'b1;
            default:                        is_write_op = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/cpu_control_unit_alu.sv
// Combinational ALU: computes the write-back value for every writing opcode.
module cpu_alu
    import cpu_pkg::*;
(
    input  logic [3:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [7:0]        imm8,
    output logic [DATA_W-1:0] y
);

    // Select the result for the current opcode; non-writing ops yield zero
    always_comb begin
        y = '0;
        case (op)
            OP_ADD:  y = a + b;
            OP_SUB:  y = a - b;
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_MOV:  y = a;
            OP_LDI:  y = {8'h00, imm8};
            OP_SHL:  y = {a[DATA_W-2:0], 1'b0};
            OP_SHR:  y = {1'b0, a[DATA_W-1:1]};
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/cpu_control_unit.sv
// Multi-cycle FETCH/DECODE/EXEC/WB controller for the 16-bit CPU core.
// Fetches over a req/valid handshake, drives register file reads and
// writes, and computes results through cpu_alu.
module cpu_control_unit
    import cpu_pkg::*;
#(
    parameter int unsigned PC_W     = 8,
    parameter int unsigned RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic              imem_valid,
    input  logic [DATA_W-1:0] imem_data,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_w_addr,
    output logic [DATA_W-1:0] rf_w_data,
    output logic [REG_AW-1:0] rf_r_addr1,
    output logic [REG_AW-1:0] rf_r_addr2,
    input  logic [DATA_W-1:0] rf_r_data1,
    input  logic [DATA_W-1:0] rf_r_data2,
    output logic              halted,
    output logic              zero_flag
);

    state_t            state;
    state_t            state_nx;
    logic [PC_W-1:0]   pc;
    logic [DATA_W-1:0] ir;
    logic [DATA_W-1:0] result;
    logic [DATA_W-1:0] alu_y;
    logic              zero_q;
    logic [3:0]        op;
    logic [7:0]        imm8;

    assign op   = ir[OP_HI:OP_LO];
    assign imm8 = ir[IMM_HI:IMM_LO];

    cpu_alu u_alu (
        .op   (op),
        .a    (rf_r_data1),
        .b    (rf_r_data2),
        .imm8 (imm8),
        .y    (alu_y)
    );

    // State register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_FETCH;
        else        state <= state_nx;
    end

    // Next-state logic and state-decoded outputs; req/we gated by reset
    always_comb begin
        state_nx   = state;
        imem_req   = 1'b0;
        rf_we      = 1'b0;
        halted     = 1'b0;
        imem_addr  = pc;
        rf_w_addr  = ir[RD_HI:RD_LO];
        rf_w_data  = result;
        rf_r_addr1 = ir[RS1_HI:RS1_LO];
        rf_r_addr2 = ir[RS2_HI:RS2_LO];
        zero_flag  = zero_q;
        case (state)
            ST_FETCH: begin
                imem_req = rst_n;
                if (imem_valid) state_nx = ST_DECODE;
            end
            ST_DECODE: state_nx = ST_EXEC;
            ST_EXEC: begin
                if (op == OP_HALT)        state_nx = ST_HALT;
                else if (is_write_op(op)) state_nx = ST_WB;
                else                      state_nx = ST_FETCH;
            end
            ST_WB: begin
                rf_we    = rst_n;
                state_nx = ST_FETCH;
            end
            ST_HALT: begin
                halted   = 1'b1;
                state_nx = ST_HALT;
            end
            default: state_nx = ST_FETCH;
        endcase
    end

    // Datapath registers: PC, instruction, result and zero flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc     <= PC_W'(RESET_PC);
            ir     <= '0;
            result <= '0;
            zero_q <= 1'b0;
        end else begin
            case (state)
                ST_FETCH: begin
                    if (imem_valid) begin
                        ir <= imem_data;
                        pc <= pc + 1'b1;
                    end
                end
                ST_EXEC: begin
                    result <= alu_y;
                    if (op == OP_JMP || (op == OP_BEQZ && rf_r_data1 == '0))
                        pc <= PC_W'(imm8);
                end
                ST_WB: zero_q <= (result == '0);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_control_unit.sv
// Directed, table-driven bench for cpu_control_unit with a behavioural
// instruction memory and a negedge-read register file.
module tb_cpu_control_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_valid;
    logic [15:0] imem_data;
    logic        rf_we;
    logic [1:0]  rf_w_addr;
    logic [15:0] rf_w_data;
    logic [1:0]  rf_r_addr1;
    logic [1:0]  rf_r_addr2;
    logic [15:0] rf_r_data1;
    logic [15:0] rf_r_data2;
    logic        halted;
    logic        zero_flag;

    logic [15:0] mem [256];
    logic [15:0] regs [4];

    int n_checks = 0;
    int n_fail   = 0;

    cpu_control_unit #(.PC_W(8), .RESET_PC(0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_valid (imem_valid),
        .imem_data  (imem_data),
        .rf_we      (rf_we),
        .rf_w_addr  (rf_w_addr),
        .rf_w_data  (rf_w_data),
        .rf_r_addr1 (rf_r_addr1),
        .rf_r_addr2 (rf_r_addr2),
        .rf_r_data1 (rf_r_data1),
        .rf_r_data2 (rf_r_data2),
        .halted     (halted),
        .zero_flag  (zero_flag)
    );

    always #5 clk = ~clk;

    assign imem_data = mem[imem_addr];

    // Register file model: write on posedge, read data refreshed on negedge
    always @(posedge clk) if (rf_we === 1'b1) regs[rf_w_addr] <= rf_w_data;
    always @(negedge clk) begin
        rf_r_data1 <= regs[rf_r_addr1];
        rf_r_data2 <= regs[rf_r_addr2];
    end

    typedef struct {
        logic [15:0] instr;
        int          exp_pulses;
        logic [1:0]  exp_wa;
        logic [15:0] exp_wd;
        int          exp_cycles;
        logic [7:0]  exp_next;
        logic        exp_zero;
    } vec_t;

    vec_t vecs [19];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Run one instruction from FETCH until the next FETCH (or halt)
    task automatic run_instr(input logic [15:0] instr, output int pulses,
                             output logic [1:0] wa, output logic [15:0] wd,
                             output int cycles);
        mem[imem_addr] = instr;
        pulses = 0;
        wa     = '0;
        wd     = '0;
        cycles = 0;
        do begin
            step();
            cycles++;
            if (rf_we === 1'b1) begin
                pulses++;
                wa = rf_w_addr;
                wd = rf_w_data;
            end
        end while (imem_req !== 1'b1 && halted !== 1'b1 && cycles < 20);
    endtask

    initial begin
        int          pulses;
        int          cycles;
        int          bad;
        logic [1:0]  wa;
        logic [15:0] wd;

        for (int i = 0; i < 256; i++) mem[i] = '0;

        vecs[0]  = '{16'h7405, 1, 2'd1, 16'h0005, 4, 8'h01, 1'b0}; // LDI R1,05
        vecs[1]  = '{16'h7803, 1, 2'd2, 16'h0003, 4, 8'h02, 1'b0}; // LDI R2,03
        vecs[2]  = '{16'h1D80, 1, 2'd3, 16'h0008, 4, 8'h03, 1'b0}; // ADD R3,R1,R2
        vecs[3]  = '{16'h2140, 1, 2'd0, 16'h0000, 4, 8'h04, 1'b1}; // SUB R0,R1,R1
        vecs[4]  = '{16'h9020, 0, 2'd0, 16'h0000, 3, 8'h20, 1'b1}; // BEQZ R0,20 taken
        vecs[5]  = '{16'h2240, 1, 2'd0, 16'hFFFE, 4, 8'h21, 1'b0}; // SUB R0,R2,R1
        vecs[6]  = '{16'h74F0, 1, 2'd1, 16'h00F0, 4, 8'h22, 1'b0}; // LDI R1,F0
        vecs[7]  = '{16'h3D80, 1, 2'd3, 16'h0000, 4, 8'h23, 1'b1}; // AND R3,R1,R2
        vecs[8]  = '{16'h4D80, 1, 2'd3, 16'h00F3, 4, 8'h24, 1'b0}; // OR  R3,R1,R2
        vecs[9]  = '{16'h5C40, 1, 2'd3, 16'hFF0E, 4, 8'h25, 1'b0}; // XOR R3,R0,R1
        vecs[10] = '{16'h6800, 1, 2'd2, 16'hFFFE, 4, 8'h26, 1'b0}; // MOV R2,R0
        vecs[11] = '{16'hA400, 1, 2'd1, 16'hFFFC, 4, 8'h27, 1'b0}; // SHL R1,R0
        vecs[12] = '{16'hB400, 1, 2'd1, 16'h7FFF, 4, 8'h28, 1'b0}; // SHR R1,R0
        vecs[13] = '{16'h1080, 1, 2'd0, 16'hFFFC, 4, 8'h29, 1'b0}; // ADD R0,R0,R2 wraps
        vecs[14] = '{16'h9040, 0, 2'd0, 16'h0000, 3, 8'h2A, 1'b0}; // BEQZ not taken
        vecs[15] = '{16'hCFFF, 0, 2'd0, 16'h0000, 3, 8'h2B, 1'b0}; // reserved
        vecs[16] = '{16'h0000, 0, 2'd0, 16'h0000, 3, 8'h2C, 1'b0}; // NOP
        vecs[17] = '{16'h80FF, 0, 2'd0, 16'h0000, 3, 8'hFF, 1'b0}; // JMP FF
        vecs[18] = '{16'h0000, 0, 2'd0, 16'h0000, 3, 8'h00, 1'b0}; // NOP at FF, wrap

        // Reset held two cycles with imem_valid asserted
        rst_n      = 1'b0;
        imem_valid = 1'b1;
        for (int c = 0; c < 2; c++) begin
            step();
            check("rst_imem_req", imem_req, 1'b0);
            check("rst_rf_we", rf_we, 1'b0);
            check("rst_halted", halted, 1'b0);
            check("rst_zero_flag", zero_flag, 1'b0);
        end
        rst_n = 1'b1;
        #1;
        check("post_rst_req", imem_req, 1'b1);
        check("post_rst_addr", imem_addr, 8'h00);

        // Table-driven program
        for (int v = 0; v < 19; v++) begin
            run_instr(vecs[v].instr, pulses, wa, wd, cycles);
            check($sformatf("v%0d_we_pulses", v), pulses, vecs[v].exp_pulses);
            if (vecs[v].exp_pulses != 0) begin
                check($sformatf("v%0d_w_addr", v), wa, vecs[v].exp_wa);
                check($sformatf("v%0d_w_data", v), wd, vecs[v].exp_wd);
            end
            check($sformatf("v%0d_cycles", v), cycles, vecs[v].exp_cycles);
            check($sformatf("v%0d_next_addr", v), imem_addr, vecs[v].exp_next);
            check($sformatf("v%0d_zero_flag", v), zero_flag, vecs[v].exp_zero);
        end

        // Memory wait states: valid withheld for 3 cycles at address 0x00
        mem[0] = 16'h745A; // LDI R1,5A
        imem_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            check("wait_req", imem_req, 1'b1);
            check("wait_addr", imem_addr, 8'h00);
        end
        imem_valid = 1'b1;
        step();
        check("wait_accept_req", imem_req, 1'b0);
        step();
        step();
        check("wait_wb_we", rf_we, 1'b1);
        check("wait_wb_data", rf_w_data, 16'h005A);
        step();
        check("wait_next_addr", imem_addr, 8'h01);
        check("wait_next_req", imem_req, 1'b1);

        // Reset on the WB cycle of ADD R2,R1,R1: no write, refetch from 0
        mem[1] = 16'h1940;
        step();
        step();
        step();
        check("rstwb_we_before", rf_we, 1'b1);
        rst_n = 1'b0;
        #1;
        check("rstwb_we_gated", rf_we, 1'b0);
        step();
        check("rstwb_req", imem_req, 1'b0);
        step();
        rst_n = 1'b1;
        #1;
        check("rstwb_restart_req", imem_req, 1'b1);
        check("rstwb_restart_addr", imem_addr, 8'h00);
        check("rstwb_r2_kept", regs[2], 16'hFFFE);

        // HALT: terminal, no fetches despite imem_valid
        run_instr(16'hF000, pulses, wa, wd, cycles);
        check("halt_cycles", cycles, 3);
        check("halt_no_write", pulses, 0);
        check("halt_flag", halted, 1'b1);
        bad = 0;
        for (int c = 0; c < 25; c++) begin
            step();
            if (imem_req !== 1'b0 || halted !== 1'b1 || rf_we !== 1'b0) bad++;
        end
        check("halt_hold_bad_cycles", bad, 0);

        // Reset leaves HALT
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        #1;
        check("unhalt_halted", halted, 1'b0);
        check("unhalt_req", imem_req, 1'b1);
        check("unhalt_addr", imem_addr, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
